// File: rtl/inv_mix_one_column.sv
// AES InvMixColumns applied to a single 4-byte state column.
// Byte r of in_col/out_col (bits 8r+7:8r) is row r of the column.
// PIPE2=0 gives a 1-cycle latency. PIPE2=1 registers the per-byte
// partial products (x09/x0b/x0d/x0e) first, which gives a 2-cycle latency.
// Data registers keep their value when no valid column arrives.
// Valid registers follow the input valid on every edge.
module inv_mix_one_column #(
  parameter int PIPE2 = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_col,
  output logic        out_valid,
  output logic [31:0] out_col
);

  // Per-row partial products of one input byte.
  typedef struct packed {
    logic [7:0] p0e;
    logic [7:0] p0b;
    logic [7:0] p0d;
    logic [7:0] p09;
  } pp_t;

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // All four inverse-matrix coefficients for one byte, built from shared x2/x4/x8.
  function automatic pp_t byte_products(input logic [7:0] b);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    pp_t        p;
    x2    = xtime(b);
    x4    = xtime(x2);
    x8    = xtime(x4);
    p.p09 = x8 ^ b;
    p.p0b = x8 ^ x2 ^ b;
    p.p0d = x8 ^ x4 ^ b;
    p.p0e = x8 ^ x4 ^ x2;
    return p;
  endfunction

  pp_t [3:0]   pp_s;       // partial products of the incoming column
  pp_t [3:0]   mix_pp_s;   // partial products feeding the XOR stage
  logic        mix_vld_s;  // valid qualifying mix_pp_s
  logic [31:0] mix_s;      // combined column result
  logic [31:0] out_col_d;
  logic [31:0] out_col_q;
  logic        out_valid_q;

  // Compute the partial products of every input byte.
  always_comb begin
    pp_s = '0;
    for (int r = 0; r < 4; r++) begin
      pp_s[r] = byte_products(in_col[8*r +: 8]);
    end
  end

  generate
    if (PIPE2 != 0) begin : g_pipe2
      pp_t [3:0] pp_d;
      pp_t [3:0] pp_q;
      logic      vld1_q;

      // Capture fresh partial products only when a valid column arrives.
      always_comb begin
        if (in_valid) begin
          pp_d = pp_s;
        end else begin
          pp_d = pp_q;
        end
      end

      // Stage-1 register for the partial products and their valid bit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pp_q   <= '0;
          vld1_q <= 1'b0;
        end else begin
          pp_q   <= pp_d;
          vld1_q <= in_valid;
        end
      end

      assign mix_pp_s  = pp_q;
      assign mix_vld_s = vld1_q;
    end else begin : g_pipe1
      assign mix_pp_s  = pp_s;
      assign mix_vld_s = in_valid;
    end
  endgenerate

  // XOR the rotated partial products into the output column.
  always_comb begin
    mix_s = 32'h0000_0000;
    for (int r = 0; r < 4; r++) begin
      mix_s[8*r +: 8] = mix_pp_s[r].p0e
                      ^ mix_pp_s[(r + 1) % 4].p0b
                      ^ mix_pp_s[(r + 2) % 4].p0d
                      ^ mix_pp_s[(r + 3) % 4].p09;
    end
  end

  // Load a new result only when the XOR stage holds valid data.
  always_comb begin
    if (mix_vld_s) begin
      out_col_d = mix_s;
    end else begin
      out_col_d = out_col_q;
    end
  end

  // Output register for the result column and its valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_col_q   <= 32'h0000_0000;
      out_valid_q <= 1'b0;
    end else begin
      out_col_q   <= out_col_d;
      out_valid_q <= mix_vld_s;
    end
  end

  assign out_col   = out_col_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_inv_mix_one_column.sv
// Self-checking bench for inv_mix_one_column.
// Both latency variants (PIPE2=0 and PIPE2=1) share the same stimulus.
// Expected values come from the known-answer vectors.
// For random stimulus they come from a generic GF(2^8) multiply reference.
module tb_inv_mix_one_column;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_col;
  logic        out_valid0;
  logic [31:0] out_col0;
  logic        out_valid1;
  logic [31:0] out_col1;

  int n_checks;
  int n_fail;

  // Expected-result history: h1 = accepted on the last edge, h2 = the edge before.
  logic        h1v, h2v;
  logic [31:0] h1e, h2e;
  logic [31:0] e0, e1;  // expected held output per variant

  logic [31:0] vin  [6];
  logic [31:0] vout [6];

  inv_mix_one_column #(.PIPE2(0)) u_dut_p0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_col    (in_col),
    .out_valid (out_valid0),
    .out_col   (out_col0)
  );

  inv_mix_one_column #(.PIPE2(1)) u_dut_p1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_col    (in_col),
    .out_valid (out_valid1),
    .out_col   (out_col1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Generic shift-and-add GF(2^8) multiply, modulus 0x11B.
  function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
    end
    return p;
  endfunction

  // Inverse MixColumns of one column: multiply by the circulant matrix (0e 0b 0d 09).
  function automatic logic [31:0] ref_col(input logic [31:0] c);
    logic [7:0]  a [4];
    logic [31:0] o;
    for (int r = 0; r < 4; r++) a[r] = c[8*r +: 8];
    o = 32'h0;
    for (int r = 0; r < 4; r++) begin
      o[8*r +: 8] = gfmul(8'h0E, a[r]) ^ gfmul(8'h0B, a[(r+1)%4])
                  ^ gfmul(8'h0D, a[(r+2)%4]) ^ gfmul(8'h09, a[(r+3)%4]);
    end
    return o;
  endfunction

  // Advance one clock edge with the current inputs and check both variants.
  task automatic tick(input logic [31:0] exp_in);
    @(posedge clk);
    #1;
    h2v = h1v;
    h2e = h1e;
    h1v = in_valid;
    h1e = exp_in;
    if (h1v) e0 = h1e;
    if (h2v) e1 = h2e;
    check("p0_valid", {31'b0, out_valid0}, {31'b0, h1v});
    check("p0_col",   out_col0, e0);
    check("p1_valid", {31'b0, out_valid1}, {31'b0, h2v});
    check("p1_col",   out_col1, e1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_p0_valid"}, {31'b0, out_valid0}, 32'h0);
    check({tag, "_p0_col"},   out_col0, 32'h0);
    check({tag, "_p1_valid"}, {31'b0, out_valid1}, 32'h0);
    check({tag, "_p1_col"},   out_col1, 32'h0);
  endtask

  // Assert reset between edges, verify the outputs clear at once, then release after an edge.
  task automatic mid_reset();
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    h1v = 1'b0;
    h2v = 1'b0;
    e0  = 32'h0;
    e1  = 32'h0;
    in_valid = 1'b1;
    in_col   = $urandom;
    @(posedge clk);
    #1;
    check_zero("rst_held");
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    h1v = 1'b0; h2v = 1'b0; h1e = 32'h0; h2e = 32'h0;
    e0 = 32'h0; e1 = 32'h0;
    vin[0] = 32'hBCA14D8E; vout[0] = 32'h455313DB;
    vin[1] = 32'hE5816604; vout[1] = 32'h305DBFD4;
    vin[2] = 32'hD6D7D5D5; vout[2] = 32'hD5D4D4D4;
    vin[3] = 32'hF8BD7E4D; vout[3] = 32'h4C31262D;
    vin[4] = 32'h01010101; vout[4] = 32'h01010101;
    vin[5] = 32'hC6C6C6C6; vout[5] = 32'hC6C6C6C6;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_col   = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Single vectors separated by idle cycles: latency and hold.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_col   = vin[i];
      tick(vout[i]);
      in_valid = 1'b0;
      in_col   = $urandom;
      tick(32'h0);
      tick(32'h0);
    end

    // Back-to-back stream of the known vectors.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_col   = vin[i];
      tick(vout[i]);
    end
    in_valid = 1'b0;
    repeat (3) tick(32'h0);

    // Random stream against the reference, with a reset in the middle.
    for (int i = 0; i < 80; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_col   = $urandom;
      tick(ref_col(in_col));
      if (i == 40) begin
        in_valid = 1'b1;
        in_col   = $urandom;
        tick(ref_col(in_col));
        mid_reset();
        repeat (3) tick(32'h0);
      end
    end

    // Idle with changing data: outputs hold and valid stays low.
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_col = $urandom;
      tick(32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
